ele_con_serial_tx: RTL and testbench

ELE_CON_SERIAL_TX -- requirements
Module: ele_con_serial_tx

---
 rtl/ele_con_serial_tx.sv | 140 ++++++++++++++
 tb/tb_ele_con_serial_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ele_con_serial_tx.sv
// ele_con_serial_tx: frames a 57-bit status word MSB-first onto sdata/sclk/sframe.
// Define ELE_SERIAL_PARITY_EN to append an even-parity bit after bit 0.
`default_nettype none

module ele_con_serial_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [56:0] status,
  output logic        sdata,
  output logic        sclk,
  output logic        sframe,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

`ifdef ELE_SERIAL_PARITY_EN
  localparam logic [5:0] LAST_BIT = 6'd57;
`else
  localparam logic [5:0] LAST_BIT = 6'd56;
`endif
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [1:0]  r_state,   w_state_nxt;
  logic [56:0] r_shift,   w_shift_nxt;
  logic [5:0]  r_bit_cnt, w_bit_nxt;
  logic [7:0]  r_div_cnt, w_div_nxt;
  logic        r_phase,   w_phase_nxt;
  logic        w_sdata_nxt;
`ifdef ELE_SERIAL_PARITY_EN
  logic        r_par,     w_par_nxt;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
`ifdef ELE_SERIAL_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_div_cnt <= w_div_nxt;
      r_phase   <= w_phase_nxt;
`ifdef ELE_SERIAL_PARITY_EN
      r_par     <= w_par_nxt;
`endif
    end
  end

  // Next-state logic; r_phase selects the low/high half of the bit period
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_cnt;
    w_div_nxt   = r_div_cnt;
    w_phase_nxt = r_phase;
`ifdef ELE_SERIAL_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SHIFT;
          w_shift_nxt = status;
          w_bit_nxt   = '0;
          w_div_nxt   = '0;
          w_phase_nxt = 1'b0;
`ifdef ELE_SERIAL_PARITY_EN
          w_par_nxt   = ^status;
`endif
        end
      end
      S_SHIFT: begin
        if (r_div_cnt == DIV_LAST) begin
          w_div_nxt = '0;
          if (!r_phase) begin
            w_phase_nxt = 1'b1;
          end else begin
            w_phase_nxt = 1'b0;
            if (r_bit_cnt == LAST_BIT) begin
              w_state_nxt = S_DONE;
            end else begin
              w_shift_nxt = {r_shift[55:0], 1'b0};
              w_bit_nxt   = r_bit_cnt + 6'd1;
            end
          end
        end else begin
          w_div_nxt = r_div_cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_bit_nxt   = '0;
        w_div_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef ELE_SERIAL_PARITY_EN
  assign w_sdata_nxt = (w_bit_nxt == 6'd57) ? w_par_nxt : w_shift_nxt[56];
`else
  assign w_sdata_nxt = w_shift_nxt[56];
`endif

  // Outputs are registered from the next-state values so they align with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdata  <= 1'b0;
      sclk   <= 1'b0;
      sframe <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      sdata  <= (w_state_nxt == S_SHIFT) && w_sdata_nxt;
      sclk   <= (w_state_nxt == S_SHIFT) && w_phase_nxt;
      sframe <= (w_state_nxt == S_SHIFT);
      busy   <= (w_state_nxt == S_SHIFT);
      done   <= (w_state_nxt == S_DONE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ele_con_serial_tx.sv
// tb_ele_con_serial_tx: randomized checks of ele_con_serial_tx against a waveform model.
`default_nettype none

module tb_ele_con_serial_tx;

`ifdef ELE_SERIAL_PARITY_EN
  localparam int NB = 58;
`else
  localparam int NB = 57;
`endif

  logic        clk;
  logic        rst_n;
  logic        start  [2];
  logic [56:0] status [2];
  logic        sdata  [2];
  logic        sclk   [2];
  logic        sframe [2];
  logic        busy   [2];
  logic        done   [2];

  int errors;
  int checks;
  logic [4:0] cap [0:1023];

  ele_con_serial_tx #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .status(status[0]),
    .sdata(sdata[0]), .sclk(sclk[0]), .sframe(sframe[0]), .busy(busy[0]), .done(done[0])
  );

  ele_con_serial_tx #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .status(status[1]),
    .sdata(sdata[1]), .sclk(sclk[1]), .sframe(sframe[1]), .busy(busy[1]), .done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] obs(input int sel);
    return {sframe[sel], busy[sel], sclk[sel], sdata[sel], done[sel]};
  endfunction

  // Expected {sframe,busy,sclk,sdata,done} at cycle c after acceptance (cycle 0)
  function automatic logic [4:0] exp_out(input logic [56:0] st, input int d, input int c);
    int len;
    int k;
    logic ph;
    logic b;
    len = NB * 2 * d;
    if (c >= 1 && c <= len) begin
      k  = (c - 1) / (2 * d);
      ph = ((c - 1) % (2 * d)) >= d;
      b  = (k < 57) ? st[56 - k] : ^st;
      return {1'b1, 1'b1, ph, b, 1'b0};
    end else if (c == len + 1) begin
      return 5'b00001;
    end
    return 5'b00000;
  endfunction

  function automatic logic [56:0] rand57();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[56:0];
  endfunction

  // Called at a negedge: raises start (cycle 0) and records outputs for cycles 1..ncyc
  task automatic run_cap(input int sel, input logic [56:0] st, input int ncyc,
                         input int hold_until, input int chg_c, input logic [56:0] chg_v);
    status[sel] = st;
    start[sel]  = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      cap[c] = obs(sel);
      if (c >= hold_until) start[sel] = 1'b0;
      if (c == chg_c) status[sel] = chg_v;
    end
    start[sel] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (obs(s) !== 5'b00000) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %b expected 00000", s, obs(s));
      end
    end
  endtask

  task automatic test_basic();
    logic [56:0] st;
    logic [4:0] e;
    int dc;
    st = 57'h1_0000_0000_0000_01;
    dc = NB * 8 + 1;
    rst_n = 1'b1;
    run_cap(0, st, dc + 2, 1, 0, '0);
    for (int c = 1; c <= dc + 2; c++) begin
      e = exp_out(st, 4, c);
      checks++;
      if (cap[c] !== e) begin
        errors++;
        $display("FAIL basic cycle %0d: got %b expected %b", c, cap[c], e);
      end
    end
    checks++;
`ifdef ELE_SERIAL_PARITY_EN
    if (cap[465] !== 5'b00001) begin
`else
    if (cap[457] !== 5'b00001) begin
`endif
      errors++;
      $display("FAIL basic_done_cycle: got %b expected 00001", cap[dc]);
    end
  endtask

  task automatic test_random();
    logic [56:0] st;
    logic [4:0] e;
    for (int n = 0; n < 4; n++) begin
      int sel;
      int d;
      sel = n % 2;
      d = (sel == 0) ? 4 : 1;
      st = rand57();
      repeat (2) @(negedge clk);
      run_cap(sel, st, NB * 2 * d + 3, 1, 0, '0);
      for (int c = 1; c <= NB * 2 * d + 3; c++) begin
        e = exp_out(st, d, c);
        checks++;
        if (cap[c] !== e) begin
          errors++;
          $display("FAIL random%0d cycle %0d: got %b expected %b", n, c, cap[c], e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [56:0] st1, st2;
    logic [4:0] e;
    int gap;
    st1 = rand57();
    st2 = ~st1;
    gap = NB * 8 + 2;
    repeat (2) @(negedge clk);
    run_cap(0, st1, gap + NB * 8 + 1, gap + 1, 200, st2);
    for (int c = 1; c <= gap + NB * 8 + 1; c++) begin
      e = (c <= gap) ? exp_out(st1, 4, c) : exp_out(st2, 4, c - gap);
      checks++;
      if (cap[c] !== e) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, cap[c], e);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_capture();
    logic [56:0] st;
    logic [4:0] e;
    st = '1;
    repeat (2) @(negedge clk);
    run_cap(0, st, NB * 8 + 2, 1, 5, '0);
    for (int c = 1; c <= NB * 8 + 2; c++) begin
      e = exp_out(st, 4, c);
      checks++;
      if (cap[c] !== e) begin
        errors++;
        $display("FAIL capture cycle %0d: got %b expected %b", c, cap[c], e);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [56:0] st;
    logic [4:0] e;
    repeat (2) @(negedge clk);
    run_cap(0, rand57(), 99, 1, 0, '0);
    checks++;
    if (cap[99] !== {2'b11, cap[99][2:1], 1'b0}) begin
      errors++;
      $display("FAIL abort_pre_frame: got %b expected 11xx0", cap[99]);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs(0) !== 5'b00000) begin
      errors++;
      $display("FAIL abort_immediate: got %b expected 00000", obs(0));
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs(0) !== 5'b00000) begin
        errors++;
        $display("FAIL abort_held cycle %0d: got %b expected 00000", c, obs(0));
      end
    end
    rst_n = 1'b1;
    st = rand57();
    run_cap(0, st, NB * 8 + 2, 1, 0, '0);
    for (int c = 1; c <= NB * 8 + 2; c++) begin
      e = exp_out(st, 4, c);
      checks++;
      if (cap[c] !== e) begin
        errors++;
        $display("FAIL abort_refill cycle %0d: got %b expected %b", c, cap[c], e);
      end
    end
  endtask

  task automatic test_parity();
    logic [56:0] st;
    logic [4:0] e;
    int p0, p1, p2;
    p0 = $urandom_range(0, 56);
    do p1 = $urandom_range(0, 56); while (p1 == p0);
    do p2 = $urandom_range(0, 56); while (p2 == p0 || p2 == p1);
    st = '0;
    st[p0] = 1'b1;
    st[p1] = 1'b1;
    st[p2] = 1'b1;
    repeat (2) @(negedge clk);
    run_cap(0, st, NB * 8 + 2, 1, 0, '0);
    for (int c = 1; c <= NB * 8 + 2; c++) begin
      e = exp_out(st, 4, c);
      checks++;
      if (cap[c] !== e) begin
        errors++;
        $display("FAIL parity cycle %0d: got %b expected %b", c, cap[c], e);
      end
    end
`ifdef ELE_SERIAL_PARITY_EN
    checks++;
    if (cap[464][1] !== 1'b1 || cap[465] !== 5'b00001) begin
      errors++;
      $display("FAIL parity_bit: got bit=%b done_vec=%b expected bit=1 done_vec=00001",
               cap[464][1], cap[465]);
    end
`endif
  endtask

  task automatic test_div1();
    logic [56:0] st;
    logic [4:0] e;
    st = 57'h1_5555_5555_5555_55;
    repeat (2) @(negedge clk);
    run_cap(1, st, 2 * NB + 2, 1, 0, '0);
    for (int c = 1; c <= 2 * NB + 2; c++) begin
      e = exp_out(st, 1, c);
      checks++;
      if (cap[c] !== e) begin
        errors++;
        $display("FAIL div1 cycle %0d: got %b expected %b", c, cap[c], e);
      end
    end
    checks++;
`ifdef ELE_SERIAL_PARITY_EN
    if (cap[117] !== 5'b00001) begin
`else
    if (cap[115] !== 5'b00001) begin
`endif
      errors++;
      $display("FAIL div1_done_cycle: got %b expected 00001", cap[2 * NB + 1]);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    status[0] = '0;
    status[1] = '0;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_capture();
    test_reset_abort();
    test_parity();
    test_div1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
